// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flexible synchronous FIFO: address-width computation
// and parameter legality checks used at elaboration time.
package sync_fifo_pkg;

   function automatic int calc_aw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit thresh_ok(input int depth, input int af, input int ae);
      return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array storage with synchronous write, a registered read port and a
// combinational read port; only the registered output is reset.
module fifo_mem_2p
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = calc_aw(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data_reg,
   output logic [DATA_W-1:0] rd_data_comb
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_d, rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_comb begin
      rd_data_comb = mem_q[rd_addr];
      rd_data_d    = rd_en ? mem_q[rd_addr] : rd_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
   end

   assign rd_data_reg = rd_data_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, programmable thresholds,
// optional first-word-fall-through, sticky error flags and synchronous flush.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   input  logic                   clr_err,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = calc_aw(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
   end
   if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
      $error("sync_fifo_flex: AF_THRESH or AE_THRESH out of range");
   end
   if (DATA_W < 1) begin : g_bad_width
      $error("sync_fifo_flex: DATA_W must be >= 1");
   end

   logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d, underflow_q, underflow_d;
   logic                wr_acc, rd_acc, full_w, empty_w;
   logic [DATA_W-1:0]   mem_rd_reg, mem_rd_comb;

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);
   assign rd_acc  = rd_en & ~empty_w;
   assign wr_acc  = wr_en & (~full_w | rd_acc);

   // Flush wins over any access in its cycle but leaves the error flags alone.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
      overflow_d  = (overflow_q & ~clr_err) | (wr_en & ~wr_acc);
      underflow_d = (underflow_q & ~clr_err) | (rd_en & empty_w);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_acc & ~flush),
      .wr_addr      (wr_ptr_q[AW-1:0]),
      .wr_data      (wr_data),
      .rd_en        (rd_acc & ~flush),
      .rd_addr      (rd_ptr_q[AW-1:0]),
      .rd_data_reg  (mem_rd_reg),
      .rd_data_comb (mem_rd_comb)
   );

   always_comb begin
      rd_data      = (FWFT != 0) ? mem_rd_comb : mem_rd_reg;
      full         = full_w;
      empty        = empty_w;
      almost_full  = (count_q >= AF_C);
      almost_empty = (count_q <= AE_C);
      count        = count_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a standard-read and an FWFT instance with identical stimulus and checks
// both against a queue-based reference model of the FIFO.
module tb_sync_fifo_flex;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [7:0] wr_data = '0;

   logic [7:0] s_rd_data, f_rd_data;
   logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0] s_count, f_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_std;
   bit         m_ovf, m_unf;

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_std (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(s_rd_data), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .clr_err(clr_err), .overflow(s_ovf), .underflow(s_unf));

   sync_fifo_flex #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .clr_err(clr_err), .overflow(f_ovf), .underflow(f_unf));

   task automatic model_reset();
      mq.delete();
      exp_std = 8'h00;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   // One clock of stimulus; the model advances on the same edge as the DUTs.
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
      bit rd_ok, wr_ok;
      @(negedge clk);
      wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
      @(posedge clk);
      rd_ok = r && (mq.size() != 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      m_ovf = (m_ovf && !c) || (w && !wr_ok);
      m_unf = (m_unf && !c) || (r && (mq.size() == 0));
      if (f) mq.delete();
      else begin
         if (rd_ok) exp_std = mq.pop_front();
         if (wr_ok) mq.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      #3;
      total++; if (s_count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", s_count); end
      total++; if (s_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b exp=1", s_empty); end
      total++; if (s_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", s_full); end
      total++; if (s_ae !== 1'b1) begin bad++; $display("[TB] FAIL reset_ae got=%b exp=1", s_ae); end
      total++; if (s_af !== 1'b0) begin bad++; $display("[TB] FAIL reset_af got=%b exp=0", s_af); end
      total++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b%b exp=00", s_ovf, s_unf); end
      total++; if (s_rd_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_rd_data got=%h exp=00", s_rd_data); end
      total++; if (f_empty !== 1'b1 || f_count !== 5'd0) begin bad++; $display("[TB] FAIL reset_fwft got=%b/%0d exp=1/0", f_empty, f_count); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         total++; if (s_count !== 5'(i)) begin bad++; $display("[TB] FAIL fill_count got=%0d exp=%0d", s_count, i); end
         total++; if (s_full !== (i == DEPTH)) begin bad++; $display("[TB] FAIL fill_full got=%b at %0d", s_full, i); end
         total++; if (s_af !== (i >= 14)) begin bad++; $display("[TB] FAIL fill_af got=%b at %0d", s_af, i); end
         total++; if (s_ae !== (i <= 2)) begin bad++; $display("[TB] FAIL fill_ae got=%b at %0d", s_ae, i); end
         total++; if (f_rd_data !== 8'h01) begin bad++; $display("[TB] FAIL fill_fwft_head got=%h exp=01", f_rd_data); end
      end
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      total++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1) begin bad++; $display("[TB] FAIL overflow_set got=%b/%b exp=1", s_ovf, f_ovf); end
      total++; if (s_count !== 5'd16 || s_full !== 1'b1) begin bad++; $display("[TB] FAIL overflow_count got=%0d exp=16", s_count); end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= DEPTH; i++) begin
         total++; if (f_rd_data !== 8'(i)) begin bad++; $display("[TB] FAIL drain_fwft_head got=%h exp=%h", f_rd_data, 8'(i)); end
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         total++; if (s_rd_data !== 8'(i)) begin bad++; $display("[TB] FAIL drain_data got=%h exp=%h", s_rd_data, 8'(i)); end
         total++; if (s_count !== 5'(DEPTH - i)) begin bad++; $display("[TB] FAIL drain_count got=%0d exp=%0d", s_count, DEPTH - i); end
      end
      total++; if (s_empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty got=%b exp=1", s_empty); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (s_unf !== 1'b1 || f_unf !== 1'b1) begin bad++; $display("[TB] FAIL underflow_set got=%b/%b exp=1", s_unf, f_unf); end
      total++; if (s_rd_data !== 8'h10) begin bad++; $display("[TB] FAIL underflow_hold got=%h exp=10", s_rd_data); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      total++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin bad++; $display("[TB] FAIL clr_err got=%b%b exp=00", s_ovf, s_unf); end
   endtask

   task automatic test_pass_through();
      logic [7:0] got[$];
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 8'hA0 + 8'(k), 1'b1, 1'b0, 1'b0);
         total++; if (s_count !== 5'd16 || s_full !== 1'b1) begin bad++; $display("[TB] FAIL pass_count got=%0d exp=16", s_count); end
         total++; if (s_ovf !== 1'b0) begin bad++; $display("[TB] FAIL pass_ovf got=%b exp=0", s_ovf); end
         total++; if (s_rd_data !== exp_std) begin bad++; $display("[TB] FAIL pass_data got=%h exp=%h", s_rd_data, exp_std); end
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         got.push_back(s_rd_data);
         total++; if (s_rd_data !== exp_std) begin bad++; $display("[TB] FAIL pass_drain got=%h exp=%h", s_rd_data, exp_std); end
      end
      for (int k = 0; k < 4; k++) begin
         total++; if (got[12 + k] !== 8'hA0 + 8'(k)) begin bad++; $display("[TB] FAIL pass_tail got=%h exp=%h", got[12 + k], 8'hA0 + 8'(k)); end
      end
   endtask

   task automatic test_fwft();
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      total++; if (f_rd_data !== 8'h55) begin bad++; $display("[TB] FAIL fwft_data got=%h exp=55", f_rd_data); end
      total++; if (f_empty !== 1'b0) begin bad++; $display("[TB] FAIL fwft_nonempty got=%b exp=0", f_empty); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (f_empty !== 1'b1) begin bad++; $display("[TB] FAIL fwft_empty got=%b exp=1", f_empty); end
      total++; if (s_rd_data !== 8'h55) begin bad++; $display("[TB] FAIL fwft_std_pop got=%h exp=55", s_rd_data); end
   endtask

   task automatic test_empty_rw();
      step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      total++; if (s_count !== 5'd1) begin bad++; $display("[TB] FAIL empty_rw_count got=%0d exp=1", s_count); end
      total++; if (s_unf !== 1'b1 || s_ovf !== 1'b0) begin bad++; $display("[TB] FAIL empty_rw_err got=%b%b exp=01", s_ovf, s_unf); end
      total++; if (f_rd_data !== 8'h77) begin bad++; $display("[TB] FAIL empty_rw_head got=%h exp=77", f_rd_data); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      total++; if (s_unf !== 1'b0 || s_rd_data !== 8'h77) begin bad++; $display("[TB] FAIL empty_rw_pop got=%b/%h exp=0/77", s_unf, s_rd_data); end
   endtask

   task automatic test_wrap_random();
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            total++; if (s_rd_data !== exp_std) begin bad++; $display("[TB] FAIL wrap_data got=%h exp=%h", s_rd_data, exp_std); end
         end
      end
      for (int n = 0; n < 400; n++) begin
         int wbias;
         wbias = ((n / 50) % 2 == 0) ? 3 : 1;
         step(($urandom % 4) < wbias, 8'($urandom), ($urandom % 4) >= wbias, 1'b0, ($urandom % 16) == 0);
         total++; if (s_count !== 5'(mq.size()) || s_count > 5'd16) begin bad++; $display("[TB] FAIL rand_count got=%0d exp=%0d", s_count, mq.size()); end
         total++; if (s_full !== (mq.size() == DEPTH) || s_empty !== (mq.size() == 0)) begin bad++; $display("[TB] FAIL rand_fe got=%b%b size=%0d", s_full, s_empty, mq.size()); end
         total++; if (s_af !== (mq.size() >= 14) || s_ae !== (mq.size() <= 2)) begin bad++; $display("[TB] FAIL rand_almost got=%b%b size=%0d", s_af, s_ae, mq.size()); end
         total++; if (s_ovf !== m_ovf || s_unf !== m_unf) begin bad++; $display("[TB] FAIL rand_err got=%b%b exp=%b%b", s_ovf, s_unf, m_ovf, m_unf); end
         total++; if (s_rd_data !== exp_std) begin bad++; $display("[TB] FAIL rand_std_data got=%h exp=%h", s_rd_data, exp_std); end
         if (mq.size() != 0) begin
            total++; if (f_rd_data !== mq[0]) begin bad++; $display("[TB] FAIL rand_fwft_data got=%h exp=%h", f_rd_data, mq[0]); end
         end
      end
   endtask

   task automatic test_flush();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      total++; if (s_count !== 5'd5) begin bad++; $display("[TB] FAIL flush_pre got=%0d exp=5", s_count); end
      step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      total++; if (s_count !== 5'd0 || s_empty !== 1'b1) begin bad++; $display("[TB] FAIL flush_clear got=%0d/%b exp=0/1", s_count, s_empty); end
      total++; if (s_rd_data !== exp_std) begin bad++; $display("[TB] FAIL flush_rd_hold got=%h exp=%h", s_rd_data, exp_std); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      total++; if (s_count !== 5'd0 || f_empty !== 1'b1) begin bad++; $display("[TB] FAIL flush_after got=%0d/%b exp=0/1", s_count, f_empty); end
   endtask

   task automatic test_async_reset();
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #1;
      model_reset();
      total++; if (s_count !== 5'd0 || s_empty !== 1'b1 || s_ae !== 1'b1) begin bad++; $display("[TB] FAIL areset_state got=%0d/%b/%b exp=0/1/1", s_count, s_empty, s_ae); end
      total++; if (s_unf !== 1'b0 || s_ovf !== 1'b0) begin bad++; $display("[TB] FAIL areset_err got=%b%b exp=00", s_ovf, s_unf); end
      total++; if (s_rd_data !== 8'h00) begin bad++; $display("[TB] FAIL areset_rd got=%h exp=00", s_rd_data); end
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      total++; if (s_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_again got=%b exp=1", s_ovf); end
      step(1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
      total++; if (s_ovf !== 1'b1) begin bad++; $display("[TB] FAIL clr_vs_new got=%b exp=1", s_ovf); end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      total++; if (s_ovf !== 1'b0 || s_ovf !== m_ovf) begin bad++; $display("[TB] FAIL clr_ovf got=%b exp=0", s_ovf); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_drain();
      test_pass_through();
      test_fwft();
      test_empty_rw();
      test_wrap_random();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
